// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: accepts one load/store at a time over a valid/ready
// handshake and holds the memory bus stable for the whole access. It waits for
// MEM_MFC and keeps the last load value in an internal MDR. It returns a
// one-cycle response that carries the data or an error flag.
// Optional feature macro: MEMSEQ_TIMEOUT_EN, which adds an access timeout that
// forces a fault after TIMEOUT ACCESS cycles.
module mem_access_sequencer #(
   parameter int READ_WAIT = 1,
   parameter int TIMEOUT   = 16
) (
   input  logic        Clock,
   input  logic        Reset_L,
   input  logic        REQ_Valid,
   output logic        REQ_Ready,
   input  logic        REQ_Write,
   input  logic [31:0] REQ_Address,
   input  logic [31:0] REQ_Data,
   output logic        RSP_Valid,
   output logic [31:0] RSP_Data,
   output logic        RSP_Error,
   output logic [31:0] MEM_Address,
   output logic [31:0] MEM_Data_In,
   output logic [1:0]  MEM_r_w_z_z,
   input  logic [31:0] MEM_Data_Out,
   input  logic        MEM_MFC,
   input  logic        MEM_ERROR
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT);
   localparam logic [1:0] BUS_IDLE  = 2'b10;

   state_t      state_reg;
   logic        write_reg;
   logic [7:0]  wait_cnt_reg;

`ifdef MEMSEQ_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]  to_cnt_reg;
   logic        timed_out;

   // The current ACCESS edge is the TIMEOUT-th one without completion
   assign timed_out = (to_cnt_reg == TO_LAST);
`else
   // TIMEOUT only matters when the timeout feature is built in
   logic [7:0]  unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
`endif

   // Sequencer FSM; every output is a register that this block updates
   always_ff @(posedge Clock) begin
      if (!Reset_L) begin
         state_reg    <= S_IDLE;
         write_reg    <= 1'b0;
         wait_cnt_reg <= 8'd0;
`ifdef MEMSEQ_TIMEOUT_EN
         to_cnt_reg   <= 8'd0;
`endif
         REQ_Ready    <= 1'b1;
         RSP_Valid    <= 1'b0;
         RSP_Data     <= 32'd0;
         RSP_Error    <= 1'b0;
         MEM_Address  <= 32'd0;
         MEM_Data_In  <= 32'd0;
         MEM_r_w_z_z  <= BUS_IDLE;
      end else begin
         RSP_Valid <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (REQ_Valid) begin
                  MEM_Address  <= REQ_Address;
                  MEM_Data_In  <= REQ_Data;
                  write_reg    <= REQ_Write;
                  wait_cnt_reg <= 8'd0;
`ifdef MEMSEQ_TIMEOUT_EN
                  to_cnt_reg   <= 8'd0;
`endif
                  RSP_Error    <= 1'b0;
                  REQ_Ready    <= 1'b0;
                  MEM_r_w_z_z  <= {1'b0, REQ_Write};
                  state_reg    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (wait_cnt_reg != WAIT_LAST)
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
`ifdef MEMSEQ_TIMEOUT_EN
               if (to_cnt_reg != 8'hFF)
                  to_cnt_reg <= to_cnt_reg + 8'd1;
`endif
               // A bus fault wins over completion; completion wins over timeout
               if (MEM_ERROR) begin
                  RSP_Error   <= 1'b1;
                  RSP_Valid   <= 1'b1;
                  MEM_r_w_z_z <= BUS_IDLE;
                  state_reg   <= S_RESP;
               end else if ((wait_cnt_reg == WAIT_LAST) && MEM_MFC) begin
                  if (!write_reg)
                     RSP_Data <= MEM_Data_Out;
                  RSP_Valid   <= 1'b1;
                  MEM_r_w_z_z <= BUS_IDLE;
                  state_reg   <= S_RESP;
               end
`ifdef MEMSEQ_TIMEOUT_EN
               else if (timed_out) begin
                  RSP_Error   <= 1'b1;
                  RSP_Valid   <= 1'b1;
                  MEM_r_w_z_z <= BUS_IDLE;
                  state_reg   <= S_RESP;
               end
`endif
            end
            S_RESP: begin
               REQ_Ready <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: begin
               REQ_Ready   <= 1'b1;
               MEM_r_w_z_z <= BUS_IDLE;
               state_reg   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer. It uses a small behavioural memory:
// words 0..127 are mapped, and any higher address raises MEM_ERROR.
// When MEMSEQ_TIMEOUT_EN is defined, the stalled-MFC case expects a timeout fault.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        Reset_L;
   logic        REQ_Valid;
   logic        REQ_Ready;
   logic        REQ_Write;
   logic [31:0] REQ_Address;
   logic [31:0] REQ_Data;
   logic        RSP_Valid;
   logic [31:0] RSP_Data;
   logic        RSP_Error;
   logic [31:0] MEM_Address;
   logic [31:0] MEM_Data_In;
   logic [1:0]  MEM_r_w_z_z;
   logic [31:0] MEM_Data_Out;
   logic        MEM_MFC;
   logic        MEM_ERROR;

   int checks   = 0;
   int failures = 0;

   logic        mem_init;
   logic [31:0] mem [0:127];

   always #5 clk = ~clk;

   mem_access_sequencer #(.READ_WAIT(1), .TIMEOUT(4)) dut (
      .Clock(clk), .Reset_L(Reset_L),
      .REQ_Valid(REQ_Valid), .REQ_Ready(REQ_Ready), .REQ_Write(REQ_Write),
      .REQ_Address(REQ_Address), .REQ_Data(REQ_Data),
      .RSP_Valid(RSP_Valid), .RSP_Data(RSP_Data), .RSP_Error(RSP_Error),
      .MEM_Address(MEM_Address), .MEM_Data_In(MEM_Data_In),
      .MEM_r_w_z_z(MEM_r_w_z_z), .MEM_Data_Out(MEM_Data_Out),
      .MEM_MFC(MEM_MFC), .MEM_ERROR(MEM_ERROR)
   );

   // Memory model: addresses from 128 upward are unmapped
   assign MEM_ERROR    = (MEM_Address >= 32'd128);
   assign MEM_Data_Out = mem[MEM_Address[6:0]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
         mem[5] <= 32'hDEADBEEF;
      end else if (MEM_r_w_z_z == 2'b01 && MEM_MFC && !MEM_ERROR) begin
         mem[MEM_Address[6:0]] <= MEM_Data_In;
      end
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one request from IDLE at a negedge and follow it to its response
   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output int bus_bad);
      bus_bad     = 0;
      REQ_Valid   = 1'b1;
      REQ_Write   = wr;
      REQ_Address = addr;
      REQ_Data    = data;
      @(negedge clk);
      REQ_Valid   = 1'b0;
      REQ_Address = 32'hFFFF_FFFF;
      REQ_Data    = 32'h0BAD_0BAD;
      lat = 1;
      while (!RSP_Valid && lat < 100) begin
         if (MEM_r_w_z_z !== {1'b0, wr} || REQ_Ready !== 1'b0) bus_bad++;
         @(negedge clk);
         lat++;
      end
      err   = RSP_Error;
      rdata = RSP_Data;
      if (MEM_r_w_z_z !== 2'b10 || REQ_Ready !== 1'b0) bus_bad++;
      @(negedge clk);
      if (REQ_Ready !== 1'b1 || RSP_Valid !== 1'b0 || MEM_r_w_z_z !== 2'b10) bus_bad++;
   endtask

   initial begin
      int          lat;
      int          bad;
      logic        err;
      logic [31:0] rdata;

      vecs[0] = '{1'b0, 32'd5,   32'd0,          1'b0, 32'hDEADBEEF, 3};
      vecs[1] = '{1'b1, 32'd70,  32'h12345678,   1'b0, 32'hDEADBEEF, 3};
      vecs[2] = '{1'b0, 32'd70,  32'd0,          1'b0, 32'h12345678, 3};
      vecs[3] = '{1'b0, 32'd200, 32'd0,          1'b1, 32'h12345678, 2};
      vecs[4] = '{1'b0, 32'd5,   32'd0,          1'b0, 32'hDEADBEEF, 3};
      vecs[5] = '{1'b1, 32'd71,  32'hA5A5A5A5,   1'b0, 32'hDEADBEEF, 3};
      vecs[6] = '{1'b0, 32'd71,  32'd0,          1'b0, 32'hA5A5A5A5, 3};
      vecs[7] = '{1'b1, 32'd300, 32'h5555AAAA,   1'b1, 32'hA5A5A5A5, 2};

      // Reset held for two edges while a request is offered
      Reset_L     = 1'b0;
      mem_init    = 1'b1;
      MEM_MFC     = 1'b1;
      REQ_Valid   = 1'b1;
      REQ_Write   = 1'b1;
      REQ_Address = 32'h55;
      REQ_Data    = 32'h66;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, REQ_Ready}, 32'd1);
      check("rst_bus", {30'd0, MEM_r_w_z_z}, 32'd2);
      check("rst_rsp_data", RSP_Data, 32'd0);
      check("rst_rsp_valid", {31'd0, RSP_Valid}, 32'd0);
      check("rst_rsp_error", {31'd0, RSP_Error}, 32'd0);
      check("rst_mem_addr", MEM_Address, 32'd0);
      check("rst_mem_data", MEM_Data_In, 32'd0);
      Reset_L   = 1'b1;
      REQ_Valid = 1'b0;
      mem_init  = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, REQ_Ready}, 32'd1);
      check("post_rst_bus", {30'd0, MEM_r_w_z_z}, 32'd2);

      // Table-driven transactions
      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, err, rdata, bad);
         $display("txn %0d wr=%0d addr=%0d lat=%0d err=%0d data=%h", i, vecs[i].wr,
                  vecs[i].addr, lat, err, rdata);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_error", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_data", i), rdata, vecs[i].exp_data);
         check($sformatf("v%0d_bus", i), 32'(bad), 32'd0);
         check($sformatf("v%0d_err_hold", i), {31'd0, RSP_Error}, {31'd0, vecs[i].exp_err});
      end

      // Stalled MFC
      MEM_MFC     = 1'b0;
      REQ_Valid   = 1'b1;
      REQ_Write   = 1'b0;
      REQ_Address = 32'd5;
      @(negedge clk);
      REQ_Valid = 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
      lat = 1;
      while (!RSP_Valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      $display("stall timeout lat=%0d err=%0d data=%h", lat, RSP_Error, RSP_Data);
      check("timeout_latency", 32'(lat), 32'd5);
      check("timeout_error", {31'd0, RSP_Error}, 32'd1);
      check("timeout_data", RSP_Data, 32'hA5A5A5A5);
      MEM_MFC = 1'b1;
`else
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (RSP_Valid !== 1'b0 || REQ_Ready !== 1'b0) bad++;
         @(negedge clk);
      end
      MEM_MFC = 1'b1;
      @(negedge clk);
      $display("stall mfc rsp_valid=%0d err=%0d data=%h", RSP_Valid, RSP_Error, RSP_Data);
      check("stall_quiet", 32'(bad), 32'd0);
      check("stall_rsp_valid", {31'd0, RSP_Valid}, 32'd1);
      check("stall_error", {31'd0, RSP_Error}, 32'd0);
      check("stall_data", RSP_Data, 32'hDEADBEEF);
`endif
      @(negedge clk);
      check("stall_ready_back", {31'd0, REQ_Ready}, 32'd1);

      // Reset in the middle of an access
      MEM_MFC     = 1'b0;
      REQ_Valid   = 1'b1;
      REQ_Write   = 1'b0;
      REQ_Address = 32'd70;
      @(negedge clk);
      REQ_Valid = 1'b0;
      @(negedge clk);
      Reset_L = 1'b0;
      @(negedge clk);
      check("midrst_bus", {30'd0, MEM_r_w_z_z}, 32'd2);
      check("midrst_ready", {31'd0, REQ_Ready}, 32'd1);
      check("midrst_rsp_valid", {31'd0, RSP_Valid}, 32'd0);
      check("midrst_rsp_data", RSP_Data, 32'd0);
      Reset_L = 1'b1;
      MEM_MFC = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (RSP_Valid !== 1'b0) bad++;
      end
      check("midrst_no_rsp", 32'(bad), 32'd0);
      do_txn(1'b0, 32'd70, 32'd0, lat, err, rdata, bad);
      $display("post-reset load lat=%0d err=%0d data=%h", lat, err, rdata);
      check("fresh_latency", 32'(lat), 32'd3);
      check("fresh_error", {31'd0, err}, 32'd0);
      check("fresh_data", rdata, 32'h12345678);
      check("fresh_bus", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
